tensor_core_result_collector: RTL and testbench
===============================================

TENSOR_CORE_RESULT_COLLECTOR -- requirements
Module: tensor_core_result_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4; meaning: number of complete 3x3 result matrices buffered; power of two, at least 2.
REQ-002 SHALL have parameter BUS_WIDTH, default 8; meaning: element width in bits, signed.
REQ-003 SHALL have clock_in  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have reset_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have capture_valid_in  input  1  high when capture_data_in holds one element of a result matrix.
REQ-006 SHALL have capture_data_in  input  BUS_WIDTH  signed element, driven from tensor_core_controller_output.
REQ-007 SHALL have clear_in  input  1  synchronous flush of the partial matrix, the FIFO and the overflow flag.
REQ-008 SHALL have result_ready_in  input  1  host accepts the head matrix.
REQ-009 SHALL have result_valid_out  output  1  head matrix is available.
REQ-010 SHALL have result_data_out  output  9*BUS_WIDTH  packed head matrix.
REQ-011 SHALL have result_count_out  output  clog2(FIFO_DEPTH)+1  number of buffered matrices.
REQ-012 SHALL have element_index_out  output  4  position of the next element within the matrix being assembled (0..8).
REQ-013 SHALL have overflow_out  output  1  sticky flag: one or more matrices were dropped.

Function
REQ-014 SHALL accept one element per cycle when capture_valid_in=1, with no backpressure to the producer.
REQ-015 SHALL pack the elements in row-major order: element k (k=0..8) goes to result_data_out[BUS_WIDTH*k +: BUS_WIDTH], so k=0 is row 0 col 0 and k=8 is row 2 col 2.
REQ-016 SHALL use two FSM states: COLLECT, entered from reset, and COMMIT, entered for one cycle after element 8 is accepted.
REQ-017 SHALL go from COMMIT back to COLLECT unconditionally; an element arriving during COMMIT SHALL be accepted as element 0 of the next matrix.
REQ-018 SHALL increment element_index_out on each accepted element and wrap it from 8 to 0 on the element-8 acceptance.
REQ-019 SHALL, in COMMIT, push the assembled matrix into the FIFO; result_valid_out SHALL rise in the cycle after COMMIT (latency from element-8 edge to valid: 2 cycles).
REQ-020 SHALL transfer the head matrix when result_valid_out=1 and result_ready_in=1; result_data_out SHALL hold stable while valid=1 and ready=0.
REQ-021 SHALL, on a push and pop in the same cycle, leave the count unchanged; the push SHALL be accepted even when the FIFO is full.
REQ-022 SHALL, on a push to a full FIFO with no pop in that cycle, discard the matrix, set overflow_out, and leave the FIFO contents unchanged.
REQ-023 SHALL keep overflow_out set until clear_in or reset.
REQ-024 SHALL, on a pop from an empty FIFO, have no effect.
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-026 SHALL give clear_in priority over capture and pop in the same cycle: element index, FSM state, FIFO pointers, count and overflow all go to 0/COLLECT on the next edge, and the data present that cycle is discarded.
REQ-027 SHALL store elements bit-exact, with no sign extension or saturation.

Reset
REQ-028 SHALL, while reset_in=0, immediately drive result_valid_out=0, result_count_out=0, element_index_out=0, overflow_out=0, result_data_out=0, and set the FSM to COLLECT.
REQ-029 SHALL discard a partial matrix when reset is asserted mid-assembly; after release, the next accepted element is element 0.
REQ-030 SHALL reset FIFO storage contents to 0.

Structure
REQ-031 SHALL take BUS_WIDTH, MATRIX_DIM=3, ELEMENTS=9, the matrix_t packed typedef and the FSM state enum from the shared package tensor_core_pkg.
REQ-032 SHALL instantiate exactly one sub-module, tensor_core_result_fifo (parameterised depth/width, valid/ready read side, full/count outputs); the collector owns the FSM and the packing.

Verification
REQ-033 Bench SHALL cover: elements 1..9 on consecutive cycles, ready=1 -> one matrix, result_data_out bytes 0..8 = 1..9, valid rises 2 cycles after element 9.
REQ-034 Bench SHALL cover: elements -128,127,-1,0,5,6,7,8,9 -> byte 0 = 0x80, byte 1 = 0x7F, byte 2 = 0xFF; no overflow.
REQ-035 Bench SHALL cover: 5 matrices with ready=0 (FIFO_DEPTH=4) -> count=4, overflow=1, and popping returns matrices 1..4 in order.
REQ-036 Bench SHALL cover: FIFO full, with the 5th matrix's COMMIT coinciding with a ready=1 pop -> count stays 4, overflow stays 0, 5th matrix is delivered last.
REQ-037 Bench SHALL cover: 4 elements, then reset_in low for 1 cycle, then 9 elements 10..18 -> a single matrix with byte 0 = 10.
REQ-038 Bench SHALL cover: clear_in with 2 matrices buffered, overflow=1 and index=3 -> next cycle count=0, valid=0, overflow=0, index=0.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// Shared types and constants for the tensor core result path.
// Holds element geometry, the packed matrix type and the collector states.
package tensor_core_pkg;

    localparam int BUS_WIDTH    = 8;
    localparam int MATRIX_DIM   = 3;
    localparam int ELEMENTS     = MATRIX_DIM * MATRIX_DIM;
    localparam int LAST_ELEMENT = ELEMENTS - 1;
    localparam int INDEX_WIDTH  = 4;

    typedef logic [ELEMENTS*BUS_WIDTH-1:0] matrix_t;

    typedef enum logic {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } collect_state_t;

    function automatic logic [INDEX_WIDTH-1:0] next_index(
        input logic [INDEX_WIDTH-1:0] idx
    );
        if (idx == INDEX_WIDTH'(LAST_ELEMENT)) begin
            return '0;
        end
        return idx + INDEX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/tensor_core_result_fifo.sv
// Matrix FIFO with push side and valid/ready pop side.
// A push is taken when not full, or when a pop frees the head slot that same edge.
module tensor_core_result_fifo
    import tensor_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(matrix_t),
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop;
    logic             do_push;

    assign out_valid = (cnt != '0);
    assign full      = (cnt == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign do_push   = push && (!full || pop);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/tensor_core_result_collector.sv
// Assembles streamed 3x3 result elements into row-major matrices
// and queues them for the host through a small matrix FIFO.
module tensor_core_result_collector
    import tensor_core_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BUS_WIDTH  = tensor_core_pkg::BUS_WIDTH,
    localparam int MW = ELEMENTS * BUS_WIDTH,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 capture_valid_in,
    input  logic [BUS_WIDTH-1:0] capture_data_in,
    input  logic                 clear_in,
    input  logic                 result_ready_in,
    output logic                 result_valid_out,
    output logic [MW-1:0]        result_data_out,
    output logic [CW-1:0]        result_count_out,
    output logic [3:0]           element_index_out,
    output logic                 overflow_out
);

    collect_state_t   state_q;
    collect_state_t   state_d;
    logic [3:0]       idx_q;
    logic [MW-1:0]    asm_q;
    logic [MW-1:0]    commit_q;
    logic             overflow_q;
    logic             last;
    logic             push;
    logic             full;
    logic             pop;

    assign last = (idx_q == 4'(LAST_ELEMENT));
    assign pop  = result_valid_out && result_ready_in;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            COLLECT: begin
                if (capture_valid_in && last) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                push    = 1'b1;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        if (clear_in) begin
            state_d = COLLECT;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // The finished matrix is snapshotted so the next matrix can start
    // filling asm_q during the COMMIT cycle.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            idx_q    <= '0;
            asm_q    <= '0;
            commit_q <= '0;
        end else if (clear_in) begin
            idx_q <= '0;
        end else if (capture_valid_in) begin
            idx_q <= next_index(idx_q);
            asm_q[BUS_WIDTH*idx_q +: BUS_WIDTH] <= capture_data_in;
            if (last) begin
                commit_q <= {capture_data_in,
                             asm_q[LAST_ELEMENT*BUS_WIDTH-1:0]};
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            overflow_q <= 1'b0;
        end else if (clear_in) begin
            overflow_q <= 1'b0;
        end else if (push && full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    tensor_core_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MW)
    ) u_fifo (
        .clk       (clock_in),
        .rst_n     (reset_in),
        .clear     (clear_in),
        .push      (push),
        .push_data (commit_q),
        .out_valid (result_valid_out),
        .out_ready (result_ready_in),
        .out_data  (result_data_out),
        .full      (full),
        .count     (result_count_out)
    );

    assign element_index_out = idx_q;
    assign overflow_out      = overflow_q;

endmodule

// File: tb/tb_tensor_core_result_collector.sv
// Directed bench for tensor_core_result_collector.
module tb_tensor_core_result_collector;

    localparam int BW    = 8;
    localparam int DEPTH = 4;

    logic          clock_in = 1'b0;
    logic          reset_in = 1'b0;
    logic          capture_valid_in = 1'b0;
    logic [BW-1:0] capture_data_in = '0;
    logic          clear_in = 1'b0;
    logic          result_ready_in = 1'b0;
    logic          result_valid_out;
    logic [9*BW-1:0] result_data_out;
    logic [2:0]    result_count_out;
    logic [3:0]    element_index_out;
    logic          overflow_out;

    int n_checks = 0;
    int n_fail   = 0;

    tensor_core_result_collector #(
        .FIFO_DEPTH (DEPTH),
        .BUS_WIDTH  (BW)
    ) dut (
        .clock_in          (clock_in),
        .reset_in          (reset_in),
        .capture_valid_in  (capture_valid_in),
        .capture_data_in   (capture_data_in),
        .clear_in          (clear_in),
        .result_ready_in   (result_ready_in),
        .result_valid_out  (result_valid_out),
        .result_data_out   (result_data_out),
        .result_count_out  (result_count_out),
        .element_index_out (element_index_out),
        .overflow_out      (overflow_out)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic send_elem(input logic [BW-1:0] v);
        capture_valid_in = 1'b1;
        capture_data_in  = v;
        tick();
        capture_valid_in = 1'b0;
    endtask

    task automatic send_matrix(input int base);
        for (int k = 0; k < 9; k++) send_elem(8'(base + k));
        tick();
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        #3;
        n_checks++;
        if (result_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %0b exp 0", result_valid_out);
        end
        n_checks++;
        if (result_count_out !== 3'd0) begin
            n_fail++; $display("FAIL reset_count got %0d exp 0", result_count_out);
        end
        n_checks++;
        if (element_index_out !== 4'd0) begin
            n_fail++; $display("FAIL reset_index got %0d exp 0", element_index_out);
        end
        n_checks++;
        if (overflow_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow got %0b exp 0", overflow_out);
        end
        n_checks++;
        if (result_data_out !== '0) begin
            n_fail++; $display("FAIL reset_data got %h exp 0", result_data_out);
        end
        tick();
        reset_in = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        result_ready_in = 1'b1;
        for (int k = 1; k <= 9; k++) send_elem(8'(k));
        n_checks++;
        if (element_index_out !== 4'd0) begin
            n_fail++; $display("FAIL basic_index_wrap got %0d exp 0", element_index_out);
        end
        n_checks++;
        if (result_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL basic_valid_commit got %0b exp 0", result_valid_out);
        end
        tick();
        n_checks++;
        if (result_valid_out !== 1'b1) begin
            n_fail++; $display("FAIL basic_valid_rise got %0b exp 1", result_valid_out);
        end
        n_checks++;
        if (result_count_out !== 3'd1) begin
            n_fail++; $display("FAIL basic_count got %0d exp 1", result_count_out);
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (result_data_out[8*k +: 8] !== 8'(k + 1)) begin
                n_fail++;
                $display("FAIL basic_byte%0d got %h exp %h", k,
                         result_data_out[8*k +: 8], 8'(k + 1));
            end
        end
        tick();
        result_ready_in = 1'b0;
        n_checks++;
        if (result_count_out !== 3'd0) begin
            n_fail++; $display("FAIL basic_pop_count got %0d exp 0", result_count_out);
        end
    endtask

    task automatic test_signed();
        logic [7:0] vals [9];
        vals = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        for (int k = 0; k < 9; k++) send_elem(vals[k]);
        tick();
        n_checks++;
        if (result_data_out[7:0] !== 8'h80) begin
            n_fail++; $display("FAIL signed_byte0 got %h exp 80", result_data_out[7:0]);
        end
        n_checks++;
        if (result_data_out[15:8] !== 8'h7F) begin
            n_fail++; $display("FAIL signed_byte1 got %h exp 7f", result_data_out[15:8]);
        end
        n_checks++;
        if (result_data_out[23:16] !== 8'hFF) begin
            n_fail++; $display("FAIL signed_byte2 got %h exp ff", result_data_out[23:16]);
        end
        n_checks++;
        if (overflow_out !== 1'b0) begin
            n_fail++; $display("FAIL signed_overflow got %0b exp 0", overflow_out);
        end
        result_ready_in = 1'b1;
        tick();
        result_ready_in = 1'b0;
    endtask

    task automatic test_overflow();
        for (int m = 1; m <= 5; m++) send_matrix(m * 10);
        n_checks++;
        if (result_count_out !== 3'd4) begin
            n_fail++; $display("FAIL ovf_count got %0d exp 4", result_count_out);
        end
        n_checks++;
        if (overflow_out !== 1'b1) begin
            n_fail++; $display("FAIL ovf_flag got %0b exp 1", overflow_out);
        end
        for (int m = 1; m <= 4; m++) begin
            n_checks++;
            if (result_data_out[7:0] !== 8'(m * 10)) begin
                n_fail++;
                $display("FAIL ovf_order%0d byte0 got %0d exp %0d", m,
                         result_data_out[7:0], m * 10);
            end
            n_checks++;
            if (result_data_out[71:64] !== 8'(m * 10 + 8)) begin
                n_fail++;
                $display("FAIL ovf_order%0d byte8 got %0d exp %0d", m,
                         result_data_out[71:64], m * 10 + 8);
            end
            result_ready_in = 1'b1;
            tick();
            result_ready_in = 1'b0;
        end
        n_checks++;
        if (result_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained_valid got %0b exp 0", result_valid_out);
        end
        n_checks++;
        if (overflow_out !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky got %0b exp 1", overflow_out);
        end
    endtask

    task automatic test_clear();
        send_matrix(100);
        send_matrix(110);
        for (int k = 0; k < 3; k++) send_elem(8'(70 + k));
        n_checks++;
        if (element_index_out !== 4'd3 || result_count_out !== 3'd2) begin
            n_fail++;
            $display("FAIL clear_pre idx %0d cnt %0d exp 3 2",
                     element_index_out, result_count_out);
        end
        clear_in         = 1'b1;
        capture_valid_in = 1'b1;
        capture_data_in  = 8'd55;
        result_ready_in  = 1'b1;
        tick();
        clear_in         = 1'b0;
        capture_valid_in = 1'b0;
        result_ready_in  = 1'b0;
        n_checks++;
        if (result_count_out !== 3'd0) begin
            n_fail++; $display("FAIL clear_count got %0d exp 0", result_count_out);
        end
        n_checks++;
        if (result_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL clear_valid got %0b exp 0", result_valid_out);
        end
        n_checks++;
        if (overflow_out !== 1'b0) begin
            n_fail++; $display("FAIL clear_overflow got %0b exp 0", overflow_out);
        end
        n_checks++;
        if (element_index_out !== 4'd0) begin
            n_fail++; $display("FAIL clear_index got %0d exp 0", element_index_out);
        end
    endtask

    task automatic test_full_pop();
        for (int m = 1; m <= 4; m++) send_matrix(m * 20);
        for (int k = 0; k < 9; k++) send_elem(8'(100 + k));
        result_ready_in = 1'b1;
        tick();
        result_ready_in = 1'b0;
        n_checks++;
        if (result_count_out !== 3'd4) begin
            n_fail++; $display("FAIL fullpop_count got %0d exp 4", result_count_out);
        end
        n_checks++;
        if (overflow_out !== 1'b0) begin
            n_fail++; $display("FAIL fullpop_overflow got %0b exp 0", overflow_out);
        end
        for (int m = 2; m <= 5; m++) begin
            n_checks++;
            if (result_data_out[7:0] !== 8'(m * 20)) begin
                n_fail++;
                $display("FAIL fullpop_order%0d got %0d exp %0d", m,
                         result_data_out[7:0], m * 20);
            end
            result_ready_in = 1'b1;
            tick();
            result_ready_in = 1'b0;
        end
        n_checks++;
        if (result_count_out !== 3'd0) begin
            n_fail++; $display("FAIL fullpop_drain got %0d exp 0", result_count_out);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 4; k++) send_elem(8'(k));
        reset_in = 1'b0;
        #1;
        n_checks++;
        if (element_index_out !== 4'd0) begin
            n_fail++; $display("FAIL rstmid_index got %0d exp 0", element_index_out);
        end
        tick();
        reset_in = 1'b1;
        for (int k = 10; k <= 18; k++) send_elem(8'(k));
        tick();
        n_checks++;
        if (result_count_out !== 3'd1) begin
            n_fail++; $display("FAIL rstmid_count got %0d exp 1", result_count_out);
        end
        n_checks++;
        if (result_data_out[7:0] !== 8'd10) begin
            n_fail++; $display("FAIL rstmid_byte0 got %0d exp 10", result_data_out[7:0]);
        end
        n_checks++;
        if (result_data_out[71:64] !== 8'd18) begin
            n_fail++; $display("FAIL rstmid_byte8 got %0d exp 18", result_data_out[71:64]);
        end
        result_ready_in = 1'b1;
        tick();
        result_ready_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_clear();
        test_full_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
